mux_uart: RTL and testbench

- Parametrised multi-channel serial port (MUX) block on the CPU6 byte bus; replaces the bench's pretend-UART at F200/F201.
- Each channel has a status/data register pair, a TX FIFO with 8N1 serialiser, and an RX deserialiser with FIFO.
- Reads are combinational, matching the memory model; writes and side effects take effect on the clock edge.
- The CPU6 top level ORs `data_out` into the read mux when `sel` is high.

---
 rtl/mux_uart_pkg.sv | 25 ++
 rtl/mux_uart_fifo.sv | 55 +++++
 rtl/mux_uart.sv | 245 ++++++++++++++++++++++++
 tb/tb_mux_uart.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_uart_pkg.sv
// mux_uart_pkg
//   Shared constants for the multi-channel serial port block:
//   STATUS bit positions, per-channel register offsets and the
//   2-bit state encoding used by both the TX and RX line FSMs.
package mux_uart_pkg;

    // STATUS register bit positions: {3'b0, frame_err, overrun, tx_idle, tx_not_full, rx_avail}
    localparam int STAT_RX_AVAIL   = 0;
    localparam int STAT_TX_NOTFULL = 1;
    localparam int STAT_TX_IDLE    = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_FRAME_ERR  = 4;

    // Register selected by address[0] within a channel's pair
    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_DATA   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mux_uart_fifo.sv
// sync_fifo
//   Single-clock FIFO with an extra wrap bit on each pointer so full and
//   empty are distinguishable without a counter.
//   Ports:
//     clock, reset (async, active-low)
//     push, din  : write request and data; accepted when not full, or when
//                  a pop happens in the same cycle
//     pop        : remove head; ignored when empty
//     full, empty: status
//     head       : current head entry (undefined when empty)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mux_uart.sv
// mux_uart
//   Multi-channel 8N1 serial port on the CPU6 byte bus. Each channel has a
//   STATUS/DATA register pair at BASE+2*ch / BASE+2*ch+1, a TX FIFO feeding
//   a serialiser and an RX deserialiser feeding an RX FIFO.
//   Ports:
//     clock, reset (async, active-low)
//     address, write_en, read_en, data_in : CPU bus side
//     data_out : combinational read data, 0 when sel is low
//     sel      : address hits this block
//     txd      : serial out per channel, idle high
//     rxd      : serial in per channel, asynchronous
module mux_uart
    import mux_uart_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'hF200,
    parameter int          CHANNELS   = 1,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLK_DIV    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         address,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                sel,
    output logic [CHANNELS-1:0] txd,
    input  logic [CHANNELS-1:0] rxd
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);

    logic [15:0]                offset;
    logic [CHANNELS-1:0]        ch_hit;
    logic [CHANNELS-1:0][7:0]   status_w;
    logic [CHANNELS-1:0][7:0]   rx_data_w;

    // Addresses below BASE wrap to large offsets and fall out of range.
    assign offset = address - BASE;
    assign sel    = (offset < 16'(2 * CHANNELS));

    always_comb begin
        data_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) data_out = (address[0] == REG_DATA) ? rx_data_w[c] : status_w[c];
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             st_hit, dt_hit;
        logic             tx_push, tx_pop, tx_full, tx_empty;
        logic [7:0]       tx_head, tx_shift;
        uart_state_e      tx_state;
        logic [CNT_W-1:0] tx_cnt;
        logic [2:0]       tx_bit;
        logic             tx_line;
        logic             rx_push, rx_pop, rx_full, rx_empty;
        logic [7:0]       rx_head, rx_shift;
        uart_state_e      rx_state;
        logic [CNT_W-1:0] rx_cnt;
        logic [2:0]       rx_bit;
        logic             rx_meta, rx_s, rx_prev, rx_wait;
        logic             rx_stop_smp, fe_evt, ovr_evt, clr;
        logic             overrun, frame_err;
        logic [7:0]       st;

        assign ch_hit[i] = sel && (offset[15:1] == 15'(i));
        assign st_hit    = ch_hit[i] && (address[0] == REG_STATUS);
        assign dt_hit    = ch_hit[i] && (address[0] == REG_DATA);
        assign tx_push   = write_en && dt_hit;
        assign rx_pop    = read_en && dt_hit;
        assign clr       = read_en && st_hit;

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .din(data_in),
            .full(tx_full), .empty(tx_empty), .head(tx_head)
        );

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_shift),
            .full(rx_full), .empty(rx_empty), .head(rx_head)
        );

        // TX: load from FIFO when idle, or at the end of STOP for gapless back-to-back frames
        assign tx_pop = !tx_empty &&
                        ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == CNT_LAST)));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                tx_state <= S_IDLE;
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_line  <= 1'b1;
            end else begin
                case (tx_state)
                    S_IDLE: begin
                        tx_cnt <= '0;
                        if (!tx_empty) begin
                            tx_line  <= 1'b0;
                            tx_state <= S_START;
                        end
                    end
                    S_START: begin
                        if (tx_cnt == CNT_LAST) begin
                            tx_cnt   <= '0;
                            tx_bit   <= '0;
                            tx_line  <= tx_shift[0];
                            tx_state <= S_DATA;
                        end else begin
                            tx_cnt <= tx_cnt + CNT_ONE;
                        end
                    end
                    S_DATA: begin
                        if (tx_cnt == CNT_LAST) begin
                            tx_cnt <= '0;
                            if (tx_bit == 3'd7) begin
                                tx_line  <= 1'b1;
                                tx_state <= S_STOP;
                            end else begin
                                tx_bit  <= tx_bit + 3'd1;
                                tx_line <= tx_shift[1];
                            end
                        end else begin
                            tx_cnt <= tx_cnt + CNT_ONE;
                        end
                    end
                    S_STOP: begin
                        if (tx_cnt == CNT_LAST) begin
                            tx_cnt <= '0;
                            if (!tx_empty) begin
                                tx_line  <= 1'b0;
                                tx_state <= S_START;
                            end else begin
                                tx_state <= S_IDLE;
                            end
                        end else begin
                            tx_cnt <= tx_cnt + CNT_ONE;
                        end
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end

        // Shift register holds data only; it is always reloaded before use.
        always_ff @(posedge clock) begin
            if (tx_pop)
                tx_shift <= tx_head;
            else if ((tx_state == S_DATA) && (tx_cnt == CNT_LAST))
                tx_shift <= tx_shift >> 1;
        end

        assign txd[i] = tx_line;

        // RX: stop-bit sample decides push vs framing error
        assign rx_stop_smp = (rx_state == S_STOP) && !rx_wait && (rx_cnt == CNT_LAST);
        assign rx_push     = rx_stop_smp && rx_s;
        assign fe_evt      = rx_stop_smp && !rx_s;
        // A CPU pop in the same cycle makes room, so that case is not an overrun.
        assign ovr_evt     = rx_push && rx_full && !(rx_pop && !rx_empty);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rx_meta   <= 1'b1;
                rx_s      <= 1'b1;
                rx_prev   <= 1'b1;
                rx_state  <= S_IDLE;
                rx_cnt    <= '0;
                rx_bit    <= '0;
                rx_wait   <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                rx_meta   <= rxd[i];
                rx_s      <= rx_meta;
                rx_prev   <= rx_s;
                overrun   <= (overrun && !clr) || ovr_evt;
                frame_err <= (frame_err && !clr) || fe_evt;
                case (rx_state)
                    S_IDLE: begin
                        rx_cnt <= '0;
                        if (rx_prev && !rx_s) rx_state <= S_START;
                    end
                    S_START: begin
                        if (rx_cnt == CNT_HALF) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + CNT_ONE;
                        end
                    end
                    S_DATA: begin
                        if (rx_cnt == CNT_LAST) begin
                            rx_cnt <= '0;
                            if (rx_bit == 3'd7) rx_state <= S_STOP;
                            else                rx_bit   <= rx_bit + 3'd1;
                        end else begin
                            rx_cnt <= rx_cnt + CNT_ONE;
                        end
                    end
                    S_STOP: begin
                        // After a low stop bit, hold here until the line returns high.
                        if (rx_wait) begin
                            if (rx_s) begin
                                rx_wait  <= 1'b0;
                                rx_state <= S_IDLE;
                            end
                        end else if (rx_cnt == CNT_LAST) begin
                            rx_cnt <= '0;
                            if (rx_s) rx_state <= S_IDLE;
                            else      rx_wait  <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + CNT_ONE;
                        end
                    end
                    default: rx_state <= S_IDLE;
                endcase
            end
        end

        // LSB arrives first: shift in at the top so it ends at bit 0.
        always_ff @(posedge clock) begin
            if ((rx_state == S_DATA) && (rx_cnt == CNT_LAST))
                rx_shift <= {rx_s, rx_shift[7:1]};
        end

        always_comb begin
            st                  = '0;
            st[STAT_RX_AVAIL]   = !rx_empty;
            st[STAT_TX_NOTFULL] = !tx_full;
            st[STAT_TX_IDLE]    = (tx_state == S_IDLE) && tx_empty;
            st[STAT_OVERRUN]    = overrun;
            st[STAT_FRAME_ERR]  = frame_err;
        end

        assign status_w[i]  = st;
        assign rx_data_w[i] = rx_empty ? 8'h00 : rx_head;
    end

endmodule

// File: tb/tb_mux_uart.sv
// tb_mux_uart
//   Scoreboard bench for mux_uart with two channels. Bus reads and TX
//   writes push expected values into queues; a read monitor and one serial
//   frame monitor per txd line pop and compare as the DUT presents data.
module tb_mux_uart;

    localparam int CH    = 2;
    localparam int DIV   = 16;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   address;
    logic          write_en;
    logic          read_en;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic          sel;
    logic [CH-1:0] txd;
    logic [CH-1:0] rxd;

    mux_uart #(.BASE(16'hF200), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .address(address), .write_en(write_en),
        .read_en(read_en), .data_in(data_in), .data_out(data_out), .sel(sel),
        .txd(txd), .rxd(rxd)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] data; logic sel; } rd_exp_t;
    typedef struct { logic [7:0] data; logic b2b; } tx_exp_t;

    rd_exp_t rd_q[$];
    string   rd_nm_q[$];
    tx_exp_t tx_q0[$];
    tx_exp_t tx_q1[$];

    int     checks = 0;
    int     fails  = 0;
    longint cyc    = 0;
    logic   mon_rd = 1'b0;
    logic   tx_mon_off = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read monitor: compares data_out/sel against the queued expectation
    rd_exp_t r;
    string   rn;
    always @(negedge clock) begin
        if (mon_rd) begin
            if (rd_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_unexpected: got %0h expected no read", data_out);
            end else begin
                r  = rd_q.pop_front();
                rn = rd_nm_q.pop_front();
                check({rn, "_data"}, data_out, r.data);
                check({rn, "_sel"}, sel, r.sel);
            end
        end
    end

    // Serial frame monitor for one txd line
    task automatic tx_mon(input int ch);
        longint  s;
        longint  last_start = -100000;
        logic    ab, startb, stopb;
        logic [7:0] b;
        tx_exp_t e;
        int      qs;
        forever begin
            @(negedge clock);
            if (txd[ch] === 1'b0 && reset === 1'b1) begin
                s  = cyc;
                ab = tx_mon_off;
                repeat (DIV / 2) @(negedge clock);
                startb = txd[ch];
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clock);
                    b[k] = txd[ch];
                    ab   = ab | tx_mon_off | !reset;
                end
                repeat (DIV) @(negedge clock);
                stopb = txd[ch];
                ab    = ab | tx_mon_off | !reset;
                if (!ab) begin
                    qs = (ch == 0) ? tx_q0.size() : tx_q1.size();
                    if (qs == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL tx%0d_unexpected_frame: got %0h expected none", ch, b);
                    end else begin
                        e = (ch == 0) ? tx_q0.pop_front() : tx_q1.pop_front();
                        check($sformatf("tx%0d_start", ch), startb, 0);
                        check($sformatf("tx%0d_byte", ch), b, e.data);
                        check($sformatf("tx%0d_stop", ch), stopb, 1);
                        if (e.b2b) check($sformatf("tx%0d_gap", ch), s - last_start, 10 * DIV);
                    end
                end
                last_start = s;
            end
        end
    endtask

    initial begin
        fork
            tx_mon(0);
            tx_mon(1);
        join_none
    end

    task automatic bus_op(input logic [15:0] a, input logic we, input logic re,
                          input logic [7:0] d, input logic chk);
        @(posedge clock); #1;
        address  = a;
        write_en = we;
        read_en  = re;
        data_in  = d;
        mon_rd   = chk;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_op(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_op(a, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic re, input logic [7:0] exp,
                      input logic exp_sel, input string nm);
        rd_q.push_back('{exp, exp_sel});
        rd_nm_q.push_back(nm);
        bus_op(a, 1'b0, re, 8'h00, 1'b1);
        idle(1);
    endtask

    task automatic send_rx(input int ch, input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            rxd[ch] = fr[k];
            repeat (DIV - 1) @(posedge clock);
        end
        @(posedge clock); #1;
        rxd[ch] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int low_cnt;

    initial begin
        reset    = 1'b0;
        address  = '0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        rxd      = '1;

        // Reset
        repeat (4) @(posedge clock);
        #1;
        check("rst_txd", txd, 2'b11);
        reset = 1'b1;
        idle(3);
        check("post_rst_txd", txd, 2'b11);
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "rst_status");

        // Single TX frame
        wr(16'hF201, 8'h48);
        tx_q0.push_back('{8'h48, 1'b0});
        rd(16'hF200, 1'b0, 8'h02, 1'b1, "tx_busy_status");
        idle(80);
        rd(16'hF200, 1'b0, 8'h02, 1'b1, "tx_mid_status");
        idle(90);
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "tx_done_status");

        // TX FIFO full: 9 accepted (one goes straight to the shifter), 10th dropped
        for (int i = 0; i < 9; i++) begin
            wr(16'hF201, 8'h30 + 8'(i));
            tx_q0.push_back('{8'h30 + 8'(i), (i != 0)});
        end
        rd(16'hF200, 1'b0, 8'h00, 1'b1, "tx_full_status");
        wr(16'hF201, 8'hEE);
        idle(9 * 10 * DIV + 40);
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "burst_done_status");
        check("burst_all_sent", tx_q0.size(), 0);

        // RX single frame
        send_rx(0, 8'h5A, 1'b1);
        idle(4);
        rd(16'hF200, 1'b0, 8'h07, 1'b1, "rx_status");
        rd(16'hF201, 1'b1, 8'h5A, 1'b1, "rx_data");
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "rx_popped_status");

        // RX overrun: 9 frames, FIFO keeps the first 8
        for (int i = 0; i < 9; i++) send_rx(0, 8'h10 + 8'(i * 17), 1'b1);
        idle(4);
        rd(16'hF200, 1'b0, 8'h0F, 1'b1, "ovr_status");
        for (int i = 0; i < 8; i++) rd(16'hF201, 1'b1, 8'h10 + 8'(i * 17), 1'b1, "ovr_data");
        rd(16'hF201, 1'b1, 8'h00, 1'b1, "empty_data");
        rd(16'hF200, 1'b0, 8'h0E, 1'b1, "ovr_empty_status");

        // Framing error, then clear-on-read
        send_rx(0, 8'hA5, 1'b0);
        idle(4);
        rd(16'hF200, 1'b0, 8'h1E, 1'b1, "fe_status");
        rd(16'hF200, 1'b1, 8'h1E, 1'b1, "clr_status");
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "cleared_status");
        rd(16'hF201, 1'b0, 8'h00, 1'b1, "fe_no_push");

        // Channel 1 and out-of-range access
        wr(16'hF203, 8'h41);
        tx_q1.push_back('{8'h41, 1'b0});
        rd(16'hF204, 1'b1, 8'h00, 1'b0, "oor");
        wr(16'hF204, 8'h55);
        idle(10 * DIV + 20);
        rd(16'hF202, 1'b0, 8'h06, 1'b1, "ch1_status");
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "ch0_status");
        check("ch1_all_sent", tx_q1.size(), 0);

        // Reset mid-frame
        tx_mon_off = 1'b1;
        wr(16'hF201, 8'h00);
        idle(40);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_txd", txd, 2'b11);
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "rst_mid_status");
        @(posedge clock); #1;
        reset = 1'b1;
        low_cnt = 0;
        repeat (200) begin
            @(negedge clock);
            if (txd !== 2'b11) low_cnt++;
        end
        check("no_glitch_frame", low_cnt, 0);
        tx_mon_off = 1'b0;
        rd(16'hF200, 1'b0, 8'h06, 1'b1, "post_mid_rst_status");

        idle(4);
        check("rd_queue_drained", rd_q.size(), 0);
        check("tx0_queue_drained", tx_q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
